serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit digits per operand; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new operation; sampled only when ready=1.
REQ-005 op  input  1  0 = add (A+B+cin), 1 = subtract (A-B, i.e. A+~B+1).
REQ-006 a  input  W  operand A, sampled on accepted start.
REQ-007 b  input  W  operand B, sampled on accepted start.
REQ-008 cin  input  1  carry-in for add; ignored when op=1.
REQ-009 ready  output  1  high in IDLE only; start is accepted only when ready=1.
REQ-010 busy  output  1  high while digits are being computed (RUN).
REQ-011 done  output  1  single-cycle pulse; sum/cout/ovf valid in that cycle.
REQ-012 sum  output  W  result, held stable from done until the next accepted start.
REQ-013 cout  output  1  carry out of MSB digit (for subtract: 1 = no borrow).
REQ-014 ovf  output  1  two's-complement signed overflow of the result.

Function
REQ-015 FSM states: IDLE, RUN, DONE; IDLE -> RUN on start=1; RUN -> DONE when digit index = NIBBLES-1; DONE -> IDLE unconditionally.
REQ-016 On accepted start: latch a, effective B (b when op=0, ~b when op=1), and carry register (cin when op=0, 1 when op=1); clear digit index to 0; clear sum register.
REQ-017 Each RUN cycle: one 4-bit add of digit[idx] of A and effective B with carry register; write result to sum[4*idx+3:4*idx]; carry register <= digit carry-out; idx <= idx+1.
REQ-018 Digits processed LSB first; exactly NIBBLES RUN cycles per operation.
REQ-019 Latency: start accepted at edge k -> RUN at k+1..k+NIBBLES -> done=1 in cycle after edge k+NIBBLES+1 (5 cycles for NIBBLES=4); ready returns high the following cycle.
REQ-020 cout = final carry register; ovf = (A[W-1] == Beff[W-1]) && (sum[W-1] != A[W-1]); both registered, updated in the RUN->DONE transition, held until next accepted start.
REQ-021 start while busy or in DONE: ignored, no effect on in-flight operation or latched operands.
REQ-022 Changes on a, b, op, cin after acceptance: no effect on the in-flight result.
REQ-023 Digit index wraps only via FSM exit; index never exceeds NIBBLES-1.
REQ-024 Back-to-back: start held high continuously yields one operation every NIBBLES+2 cycles.

Reset
REQ-025 reset=1 at a rising edge: state IDLE, ready=1, busy=0, done=0, sum=0, cout=0, ovf=0, idx=0, carry=0.
REQ-026 reset mid-operation aborts it; no done pulse for the aborted operation; reset has priority over start.

Structure
REQ-027 Shared package holds state enum (IDLE, RUN, DONE) and the digit width constant (4).
REQ-028 One sub-module: a single instance of the existing 4-bit ripple adder adder4bit, reused every RUN cycle; no other arithmetic on the datapath.

Verification
REQ-029 Add: a=0x1234, b=0x0FFF, cin=0, op=0 -> done 5 cycles after start, sum=0x2233, cout=0, ovf=0.
REQ-030 Wrap: a=0xFFFF, b=0x0001, cin=0, op=0 -> sum=0x0000, cout=1, ovf=0.
REQ-031 Subtract: a=0x0005, b=0x0007, op=1, cin=1 -> sum=0xFFFE, cout=0 (borrow), ovf=0.
REQ-032 Overflow: a=0x7FFF, b=0x0001, op=0, cin=0 -> sum=0x8000, ovf=1, cout=0.
REQ-033 Start pulsed during RUN with different operands -> ignored; original result delivered, ready low until after done.
REQ-034 reset asserted in 2nd RUN cycle -> next cycle all outputs at reset values, no done; fresh start then completes correctly.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package serial_add_ctrl_pkg;
  localparam int DIGIT_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result bundle between a requester and serial_add_ctrl.
interface serial_add_ctrl_if #(parameter int NIBBLES = 4);
  localparam int W = 4 * NIBBLES;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (output start, op, a, b, cin,
                  input  ready, busy, done, sum, cout, ovf);
  modport slave  (input  start, op, a, b, cin,
                  output ready, busy, done, sum, cout, ovf);
endinterface

// File: rtl/adder4bit.sv
// 4-bit ripple-carry adder built from per-bit full adders.
module adder4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[4];
endmodule

// File: rtl/serial_add_ctrl.sv
// Digit-serial add/subtract: one 4-bit digit per RUN cycle, LSB first,
// through a single shared adder4bit.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input logic              clk,
  input logic              reset,
  serial_add_ctrl_if.slave bus
);
  localparam int W  = DIGIT_W * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t               state, nxt;
  logic [W-1:0]         a_q, b_q, sum_q;
  logic                 carry_q, cout_q, ovf_q;
  logic [IW-1:0]        idx;
  logic [DIGIT_W-1:0]   da, db, ds;
  logic                 dco, last;

  assign last = (idx == IW'(NIBBLES - 1));
  assign da   = a_q[int'(idx)*DIGIT_W +: DIGIT_W];
  assign db   = b_q[int'(idx)*DIGIT_W +: DIGIT_W];

  adder4bit u_add (.a(da), .b(db), .ci(carry_q), .s(ds), .co(dco));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.start) nxt = RUN;
      RUN:     if (last)      nxt = DONE;
      DONE:                   nxt = IDLE;
      default:                nxt = IDLE;
    endcase
  end

  // b_q holds the effective B so RUN cycles never need to know the op.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          a_q     <= bus.a;
          b_q     <= bus.op ? ~bus.b : bus.b;
          carry_q <= bus.op ? 1'b1 : bus.cin;
          sum_q   <= '0;
          idx     <= '0;
        end
        RUN: begin
          sum_q[int'(idx)*DIGIT_W +: DIGIT_W] <= ds;
          carry_q <= dco;
          if (last) begin
            idx    <= '0;
            cout_q <= dco;
            ovf_q  <= (a_q[W-1] == b_q[W-1]) && (ds[DIGIT_W-1] != a_q[W-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized bench for serial_add_ctrl against a cycle-count reference model.
module tb_serial_add_ctrl;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  serial_add_ctrl_if #(.NIBBLES(N)) tif ();
  serial_add_ctrl #(.NIBBLES(N)) dut (.clk(clk), .reset(reset), .bus(tif));

  always #5 clk = ~clk;

  // {ovf, cout, sum} straight from the arithmetic definition
  function automatic logic [W+1:0] ref_res(input logic [W-1:0] x, y,
                                           input logic o, c);
    logic [W-1:0] ye;
    logic [W:0]   f, cc;
    logic         v;
    ye = o ? ~y : y;
    cc = '0;
    cc[0] = o ? 1'b1 : c;
    f  = {1'b0, x} + {1'b0, ye} + cc;
    v  = (x[W-1] == ye[W-1]) && (f[W-1] != x[W-1]);
    return {v, f};
  endfunction

  // Model: ph=0 idle, 1..N computing, N+1 result cycle.
  int             ph = 0;
  bit             chk_en = 1'b0;
  logic [W-1:0]   e_sum = '0;
  logic           e_cout = 1'b0, e_ovf = 1'b0;
  logic [W+1:0]   pend = '0;

  always @(posedge clk) begin
    chk_en <= 1'b1;
    if (reset) begin
      ph <= 0; e_sum <= '0; e_cout <= 1'b0; e_ovf <= 1'b0;
    end else if (ph == 0) begin
      if (tif.start) begin
        ph   <= 1;
        pend <= ref_res(tif.a, tif.b, tif.op, tif.cin);
      end
    end else if (ph <= N) begin
      ph <= ph + 1;
      if (ph == N) begin
        e_sum <= pend[W-1:0]; e_cout <= pend[W]; e_ovf <= pend[W+1];
      end
    end else begin
      ph <= 0;
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (chk_en) begin
      chk("ready", W'(tif.ready), W'(ph == 0));
      chk("busy",  W'(tif.busy),  W'(ph >= 1 && ph <= N));
      chk("done",  W'(tif.done),  W'(ph == N + 1));
      if (ph == 0 || ph == N + 1) begin
        chk("sum",  tif.sum,        e_sum);
        chk("cout", W'(tif.cout),   W'(e_cout));
        chk("ovf",  W'(tif.ovf),    W'(e_ovf));
      end
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta, tb_, input logic top, tcin,
                        input bit intf, output logic [W-1:0] rs,
                        output logic rc, ro, output int lat);
    int g = 0;
    while (!tif.ready && g < 50) begin cyc(); g++; end
    if (!tif.ready) chk("ready_wait", W'(tif.ready), W'(1));
    tif.start = 1'b1; tif.a = ta; tif.b = tb_; tif.op = top; tif.cin = tcin;
    lat = 0;
    do begin
      cyc();
      lat++;
      if (lat == 1) begin
        tif.start = 1'b0;
        tif.a = W'($urandom); tif.b = W'($urandom);
        tif.op = 1'($urandom); tif.cin = 1'($urandom);
      end
      if (intf && lat == 2) begin
        tif.start = 1'b1;
        chk("ready_low_run", W'(tif.ready), W'(0));
      end
      if (intf && lat == 3) tif.start = 1'b0;
    end while (!tif.done && lat < 20);
    if (!tif.done) chk("done_timeout", W'(tif.done), W'(1));
    rs = tif.sum; rc = tif.cout; ro = tif.ovf;
    if (intf) begin
      // start during DONE must be ignored too
      tif.start = 1'b1; tif.a = W'($urandom); tif.b = W'($urandom);
      cyc();
      tif.start = 1'b0;
    end
  endtask

  initial begin
    logic [W-1:0] rs;
    logic         rc, ro;
    int           lat, prev, nd;

    tif.start = 1'b0; tif.a = '0; tif.b = '0; tif.op = 1'b0; tif.cin = 1'b0;
    reset = 1'b1;
    cyc(); cyc();
    chk("rst_ready", W'(tif.ready), W'(1));
    chk("rst_busy",  W'(tif.busy),  W'(0));
    chk("rst_done",  W'(tif.done),  W'(0));
    chk("rst_sum",   tif.sum,       W'(0));
    reset = 1'b0;
    cyc();

    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0, rs, rc, ro, lat);
    chk("add_sum", rs, 16'h2233); chk("add_cout", W'(rc), W'(0));
    chk("add_ovf", W'(ro), W'(0)); chk("add_lat", W'(lat), W'(5));

    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, rs, rc, ro, lat);
    chk("wrap_sum", rs, 16'h0000); chk("wrap_cout", W'(rc), W'(1));
    chk("wrap_ovf", W'(ro), W'(0));

    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, rs, rc, ro, lat);
    chk("sub_sum", rs, 16'hFFFE); chk("sub_cout", W'(rc), W'(0));
    chk("sub_ovf", W'(ro), W'(0));

    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, rs, rc, ro, lat);
    chk("ovf_sum", rs, 16'h8000); chk("ovf_cout", W'(rc), W'(0));
    chk("ovf_ovf", W'(ro), W'(1)); chk("ovf_lat", W'(lat), W'(5));

    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, rs, rc, ro, lat);
    chk("subovf_sum", rs, 16'h7FFF); chk("subovf_cout", W'(rc), W'(1));
    chk("subovf_ovf", W'(ro), W'(1));

    // abort in the second RUN cycle; reset wins over start
    tif.start = 1'b1; tif.a = 16'hAAAA; tif.b = 16'h5555; tif.op = 1'b0;
    cyc();
    tif.start = 1'b0;
    cyc();
    reset = 1'b1; tif.start = 1'b1;
    cyc();
    chk("abort_ready", W'(tif.ready), W'(1));
    chk("abort_busy",  W'(tif.busy),  W'(0));
    chk("abort_done",  W'(tif.done),  W'(0));
    chk("abort_sum",   tif.sum,       W'(0));
    chk("abort_cout",  W'(tif.cout),  W'(0));
    chk("abort_ovf",   W'(tif.ovf),   W'(0));
    cyc();
    chk("rst_prio_ready", W'(tif.ready), W'(1));
    reset = 1'b0; tif.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("no_done_after_abort", W'(tif.done), W'(0));
    end
    run_op(16'h00F0, 16'h0F0F, 1'b0, 1'b1, 1'b0, rs, rc, ro, lat);
    chk("fresh_sum", rs, 16'h1000); chk("fresh_cout", W'(rc), W'(0));
    chk("fresh_lat", W'(lat), W'(5));

    // start held high: one result every N+2 cycles
    tif.start = 1'b1; prev = -1; nd = 0;
    for (int i = 0; i < 40; i++) begin
      tif.a = W'($urandom); tif.b = W'($urandom);
      tif.op = 1'($urandom); tif.cin = 1'($urandom);
      cyc();
      if (tif.done) begin
        if (prev >= 0) chk("b2b_gap", W'(i - prev), W'(N + 2));
        prev = i; nd++;
      end
    end
    tif.start = 1'b0;
    chk("b2b_count", W'(nd >= 5), W'(1));

    for (int k = 0; k < 150; k++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom); rb = W'($urandom);
      if (k % 10 == 0) ra = 16'h7FFF;
      if (k % 10 == 1) rb = 16'hFFFF;
      run_op(ra, rb, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
             rs, rc, ro, lat);
      chk("rnd_lat", W'(lat), W'(N + 1));
    end
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
